// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states, counter sizing.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } snadd_state_t;

    // A one-nibble operand still needs a one-bit counter.
    function automatic int cnt_width(input int nib);
        int w;
        w = $clog2(nib);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_nibble_adder_if.sv
// Operand/result handshake bundle for serial_nibble_adder; master = producer/consumer, slave = adder.
interface serial_nibble_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_nibble_adder_full_adder.sv
// 4-bit combinational adder cell with carry in/out; zero latency, no handshake.
module full_adder
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                ci_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, ci_i};

endmodule

// File: rtl/serial_nibble_adder.sv
// Wide a+b+cin computed one nibble per clock; result valid WIDTH/4 cycles after accept.
// Accepts only in IDLE; holds sum/cout in DONE until out_ready, with no same-cycle re-accept.
module serial_nibble_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_nibble_adder_if.slave bus
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = cnt_width(NIB);

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("serial_nibble_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    snadd_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [NIBBLE_W-1:0] fa_s;
    logic                fa_co;
    logic                last_nib;

    full_adder u_full_adder (
        .a_i  (a_q[NIBBLE_W-1:0]),
        .b_i  (b_q[NIBBLE_W-1:0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    assign last_nib = (cnt_q == CNT_W'(NIB - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // LSB nibble first: each new result nibble enters at the top and shifts down.
                sum_d   = (sum_q >> NIBBLE_W) | (WIDTH'(fa_s) << (WIDTH - NIBBLE_W));
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_nib) begin
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Self-checking bench for serial_nibble_adder at WIDTH 16, 4 and 32.
module tb_serial_nibble_adder;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    serial_nibble_adder_if #(.WIDTH(16)) if16 ();
    serial_nibble_adder_if #(.WIDTH(4))  if4  ();
    serial_nibble_adder_if #(.WIDTH(32)) if32 ();

    serial_nibble_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    serial_nibble_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    serial_nibble_adder #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer sum; bits [w-1:0] are the result, bit w the carry out.
    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + 65'(cin);
    endfunction

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        if16.a        = a;
        if16.b        = b;
        if16.cin      = cin;
        if16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if16.in_valid = 1'b0;
    endtask

    task automatic wait_done16(output int lat);
        lat = 0;
        while (!if16.out_valid && lat < 64) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain16();
        if16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if16.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        tbl[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        tbl[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

        if16.in_valid = 0; if16.a = '0; if16.b = '0; if16.cin = 0; if16.out_ready = 0;
        if4.in_valid  = 0; if4.a  = '0; if4.b  = '0; if4.cin  = 0; if4.out_ready  = 0;
        if32.in_valid = 0; if32.a = '0; if32.b = '0; if32.cin = 0; if32.out_ready = 0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(if16.in_ready),  64'd1);
        chk("rst_out_valid", 64'(if16.out_valid), 64'd0);
        chk("rst_sum",       64'(if16.sum),       64'd0);
        chk("rst_cout",      64'(if16.cout),      64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            start16(tbl[i].a, tbl[i].b, tbl[i].cin);
            wait_done16(lat);
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("tbl%0d_sum", i),  64'(if16.sum),  64'(tbl[i].s));
            chk($sformatf("tbl%0d_cout", i), 64'(if16.cout), 64'(tbl[i].co));
            drain16();
            chk($sformatf("tbl%0d_in_ready", i), 64'(if16.in_ready), 64'd1);
        end

        // Backpressure: result held, new operands ignored while in DONE.
        start16(16'h2222, 16'h3333, 1'b1);
        wait_done16(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                if16.a = 16'hFFFF; if16.b = 16'hFFFF; if16.cin = 1'b1; if16.in_valid = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if16.in_valid = 1'b0;
            chk("bp_sum",       64'(if16.sum),       64'h5556);
            chk("bp_cout",      64'(if16.cout),      64'd0);
            chk("bp_in_ready",  64'(if16.in_ready),  64'd0);
            chk("bp_out_valid", 64'(if16.out_valid), 64'd1);
        end
        drain16();
        chk("bp_release_in_ready",  64'(if16.in_ready),  64'd1);
        chk("bp_release_out_valid", 64'(if16.out_valid), 64'd0);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_no_ghost_op",  64'(if16.out_valid), 64'd0);
        chk("bp_sum_retained", 64'(if16.sum),       64'h5556);

        // Operands scrambled every RUN cycle must not disturb the captured values.
        if16.a = 16'h00FF; if16.b = 16'h0001; if16.cin = 1'b0; if16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if16.in_valid = 1'b0;
        lat = 0;
        while (!if16.out_valid && lat < 64) begin
            if16.a   = 16'($urandom);
            if16.b   = 16'($urandom);
            if16.cin = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("stab_latency", 64'(lat), 64'd4);
        chk("stab_sum",  64'(if16.sum),  64'h0100);
        chk("stab_cout", 64'(if16.cout), 64'd0);
        drain16();

        // Reset mid-RUN, preceded by an op that leaves cout=1 so its clearing is visible.
        start16(16'hFFFF, 16'h0001, 1'b0);
        wait_done16(lat);
        chk("pre_rst_cout", 64'(if16.cout), 64'd1);
        drain16();
        start16(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(if16.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(if16.in_ready),  64'd1);
        chk("midrst_sum",       64'(if16.sum),       64'd0);
        chk("midrst_cout",      64'(if16.cout),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midrst_no_result", 64'(if16.out_valid), 64'd0);
        start16(16'h8000, 16'h8000, 1'b0);
        wait_done16(lat);
        chk("postrst_latency", 64'(lat), 64'd4);
        chk("postrst_sum",  64'(if16.sum),  64'h0000);
        chk("postrst_cout", 64'(if16.cout), 64'd1);
        drain16();

        // Width sweep: WIDTH=4 and WIDTH=32 in parallel against the reference.
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    logic [3:0]  ra, rb;
                    logic        rc;
                    logic [64:0] ex;
                    int          l4;
                    ra = 4'($urandom);
                    rb = 4'($urandom);
                    rc = 1'($urandom);
                    ex = ref_add(64'(ra), 64'(rb), rc);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if4.a = ra; if4.b = rb; if4.cin = rc; if4.in_valid = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    if4.in_valid = 1'b0;
                    l4 = 0;
                    while (!if4.out_valid && l4 < 64) begin
                        @(posedge clk);
                        @(negedge clk);
                        l4++;
                    end
                    chk("w4_latency", 64'(l4), 64'd1);
                    chk("w4_sum",  64'(if4.sum),  64'(ex[3:0]));
                    chk("w4_cout", 64'(if4.cout), 64'(ex[4]));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if4.out_ready = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    if4.out_ready = 1'b0;
                end
            end
            begin
                for (int i = 0; i < 500; i++) begin
                    logic [31:0] ra, rb;
                    logic        rc;
                    logic [64:0] ex;
                    int          l32;
                    ra = $urandom;
                    rb = $urandom;
                    rc = 1'($urandom);
                    ex = ref_add(64'(ra), 64'(rb), rc);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if32.a = ra; if32.b = rb; if32.cin = rc; if32.in_valid = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    if32.in_valid = 1'b0;
                    l32 = 0;
                    while (!if32.out_valid && l32 < 64) begin
                        @(posedge clk);
                        @(negedge clk);
                        l32++;
                    end
                    chk("w32_latency", 64'(l32), 64'd8);
                    chk("w32_sum",  64'(if32.sum),  64'(ex[31:0]));
                    chk("w32_cout", 64'(if32.cout), 64'(ex[32]));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if32.out_ready = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    if32.out_ready = 1'b0;
                end
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
